// File: rtl/result_serializer_pkg.sv
// result_serializer_pkg: shared widths and FSM encoding for the result serializer
package result_serializer_pkg;

    localparam int OPERAND_WIDTH        = 8;
    localparam int DEFAULT_RESULT_WIDTH = 2 * OPERAND_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/result_serializer.sv
// result_serializer: splits each result word into bytes, LSB first, with a one-deep pending slot
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int RESULT_WIDTH = DEFAULT_RESULT_WIDTH,
    parameter int NUM_BYTES    = RESULT_WIDTH / 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [RESULT_WIDTH-1:0] Result,
    input  logic                    Result_Valid,
    output logic [7:0]              Out_Byte,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic                    Busy,
    output logic                    Overrun,
    input  logic                    Ovr_Clr
);

    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [RESULT_WIDTH-1:0] shift_reg;
    logic [RESULT_WIDTH-1:0] pend_reg;
    logic                    pend_full;
    logic                    overrun_q;
    logic                    xfer;
    logic                    last_xfer;
    logic                    drop;

    // A word is only dropped when the pending slot is full and is not being freed this cycle
    always_comb begin
        xfer      = (state == SEND) && Out_Ready;
        last_xfer = xfer && (idx == LAST);
        drop      = Result_Valid && (state == SEND) && pend_full && !last_xfer;
    end

    // Serializer FSM, shift register, pending slot and sticky overrun flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            idx       <= '0;
            shift_reg <= '0;
            pend_reg  <= '0;
            pend_full <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= drop | (overrun_q & ~Ovr_Clr);
            case (state)
                IDLE: begin
                    if (Result_Valid) begin
                        shift_reg <= Result;
                        idx       <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (last_xfer) begin
                        idx <= '0;
                        if (pend_full) begin
                            shift_reg <= pend_reg;
                            pend_full <= Result_Valid;
                            if (Result_Valid) pend_reg <= Result;
                        end else if (Result_Valid) begin
                            shift_reg <= Result;
                        end else begin
                            shift_reg <= '0;
                            state     <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            idx       <= idx + 1'b1;
                            shift_reg <= shift_reg >> 8;
                        end
                        if (Result_Valid && !pend_full) begin
                            pend_reg  <= Result;
                            pend_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Out_Valid = (state == SEND);
    assign Out_Byte  = Out_Valid ? shift_reg[7:0] : 8'h00;
    assign Busy      = Out_Valid | pend_full;
    assign Overrun   = overrun_q;

endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: random and directed stimulus against a word-queue reference model
module tb_result_serializer;

    localparam int NB = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] Result = '0;
    logic        Result_Valid = 1'b0;
    logic [7:0]  Out_Byte;
    logic        Out_Valid;
    logic        Out_Ready = 1'b0;
    logic        Busy;
    logic        Overrun;
    logic        Ovr_Clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: words accepted but not fully sent; head word is on the wire
    logic [15:0] wq[$];
    int          bidx = 0;
    logic        ovr = 1'b0;

    result_serializer dut (
        .CLK(CLK), .RST(RST), .Result(Result), .Result_Valid(Result_Valid),
        .Out_Byte(Out_Byte), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Busy(Busy), .Overrun(Overrun), .Ovr_Clr(Ovr_Clr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outs();
        logic [7:0] eb;
        eb = 8'h00;
        if (wq.size() > 0) eb = 8'(wq[0] >> (8 * bidx));
        check("out_valid", 32'(Out_Valid), 32'(wq.size() > 0));
        check("out_byte", 32'(Out_Byte), 32'(eb));
        check("busy", 32'(Busy), 32'(wq.size() > 0));
        check("overrun", 32'(Overrun), 32'(ovr));
    endtask

    // At most two words fit: the one on the wire and one waiting
    task automatic model_edge(input logic rv, input logic [15:0] r, input logic rdy, input logic clr);
        logic drop;
        drop = 1'b0;
        if (wq.size() > 0 && rdy) begin
            if (bidx == NB - 1) begin
                void'(wq.pop_front());
                bidx = 0;
            end else begin
                bidx++;
            end
        end
        if (rv) begin
            if (wq.size() < 2) wq.push_back(r);
            else drop = 1'b1;
        end
        if (drop) ovr = 1'b1;
        else if (clr) ovr = 1'b0;
    endtask

    task automatic step(input logic rv, input logic [15:0] r, input logic rdy, input logic clr);
        check_outs();
        Result_Valid = rv;
        Result       = r;
        Out_Ready    = rdy;
        Ovr_Clr      = clr;
        @(posedge CLK);
        model_edge(rv, r, rdy, clr);
        @(negedge CLK);
    endtask

    task automatic pulse_reset();
        Result_Valid = 1'b0;
        Out_Ready    = 1'b0;
        Ovr_Clr      = 1'b0;
        #1 RST = 1'b0;
        #1;
        wq.delete();
        bidx = 0;
        ovr  = 1'b0;
        check_outs();
        #1 RST = 1'b1;
        @(posedge CLK);
        model_edge(1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge CLK);
    endtask

    initial begin
        #2;
        check_outs();
        #5 RST = 1'b1;
        @(negedge CLK);

        // A55A streamed with ready held high
        step(1, 16'hA55A, 1, 0);
        check("a55a_b0", 32'(Out_Byte), 32'h5A);
        step(0, 16'h0, 1, 0);
        check("a55a_b1", 32'(Out_Byte), 32'hA5);
        step(0, 16'h0, 1, 0);
        check("a55a_busy", 32'(Busy), 32'h0);

        // 1234 stalled for five cycles
        step(1, 16'h1234, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("1234_hold", 32'(Out_Byte), 32'h34);
            step(0, 16'h0, 0, 0);
        end
        step(0, 16'h0, 1, 0);
        check("1234_b1", 32'(Out_Byte), 32'h12);
        step(0, 16'h0, 1, 0);

        // Three back-to-back pulses while stalled: third one dropped
        step(1, 16'h0001, 0, 0);
        step(1, 16'h0002, 0, 0);
        step(1, 16'h0003, 0, 0);
        check("ovr_set", 32'(Overrun), 32'h1);
        for (int i = 0; i < 5; i++) step(0, 16'h0, 1, 0);
        check("ovr_drain_idle", 32'(Busy), 32'h0);

        // Overrun clear alone
        step(0, 16'h0, 0, 1);
        check("ovr_clr", 32'(Overrun), 32'h0);

        // New pulse on the last-byte transfer of BEEF: no gap, no overrun
        step(1, 16'hBEEF, 1, 0);
        step(0, 16'h0, 1, 0);
        step(1, 16'h1357, 1, 0);
        check("beef_next", 32'(Out_Byte), 32'h57);
        check("beef_ovr", 32'(Overrun), 32'h0);
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 1, 0);

        // Reset while byte 0 of CAFE is stalled
        step(1, 16'hCAFE, 0, 0);
        step(0, 16'h0, 0, 0);
        check("cafe_stall", 32'(Out_Byte), 32'hFE);
        pulse_reset();
        for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 0);

        // Clear coinciding with a drop: set wins, then clear alone
        step(1, 16'h1111, 0, 0);
        step(1, 16'h2222, 0, 0);
        step(1, 16'h3333, 0, 1);
        check("setwins", 32'(Overrun), 32'h1);
        step(0, 16'h0, 0, 1);
        check("clr_after", 32'(Overrun), 32'h0);
        for (int i = 0; i < 5; i++) step(0, 16'h0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                step(logic'($urandom_range(0, 99) < 35), 16'($urandom),
                     logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 99) < 5));
            end
        end
        check_outs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter RESULT_WIDTH, default 16: result width in bits; must be a multiple of 8, at least 8.
REQ-002 SHALL have parameter NUM_BYTES, default RESULT_WIDTH/8: bytes emitted per result.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1: sole clock, rising-edge.
REQ-005 RST  input  1: asynchronous active-low reset.
REQ-006 Result  input  RESULT_WIDTH: ALU/CMP result word, zero-extended by the producer.
REQ-007 Result_Valid  input  1: qualifies Result, sampled every cycle; no backpressure to the producer.
REQ-008 Out_Byte  output  8: current byte offered downstream (TX FIFO / UART TX).
REQ-009 Out_Valid  output  1: Out_Byte is valid.
REQ-010 Out_Ready  input  1: downstream accepts Out_Byte this cycle.
REQ-011 Busy  output  1: high while a result is being sent or one is pending.
REQ-012 Overrun  output  1: sticky flag, set when a result is dropped.
REQ-013 Ovr_Clr  input  1: synchronous clear of Overrun.

Function
REQ-014 A byte transfer SHALL occur on a rising CLK edge where Out_Valid and Out_Ready are both high.
REQ-015 Bytes SHALL be sent least-significant first: byte k = Result[8k+7:8k], k = 0..NUM_BYTES-1.
REQ-016 The FSM SHALL have two states, IDLE and SEND, plus a byte index counter of width clog2(NUM_BYTES), minimum 1 bit.
REQ-017 In IDLE, Result_Valid SHALL load Result into the shift register, clear the index and enter SEND; Out_Valid goes high the next cycle (latency 1).
REQ-018 In SEND, Out_Valid SHALL be high and Out_Byte SHALL be held stable until the transfer completes.
REQ-019 On each transfer the index SHALL increment and the shift register SHALL shift right by 8.
REQ-020 On the transfer of byte NUM_BYTES-1, if the pending register is full its word SHALL load, the index SHALL clear and the FSM stays in SEND; otherwise it SHALL return to IDLE.
REQ-021 Result_Valid in SEND SHALL write a one-entry pending register if it is empty; if it is full, the word SHALL be dropped and Overrun set.
REQ-022 Result_Valid coinciding with the last-byte transfer while pending is empty SHALL load directly into the shift register, with no gap cycle and no overrun.
REQ-023 Result_Valid coinciding with the last-byte transfer while pending is full SHALL move pending into the shift register and write the new word into pending, with no overrun.
REQ-024 Ovr_Clr and a simultaneous overrun event SHALL leave Overrun set (set wins).
REQ-025 Busy SHALL equal (state == SEND) OR pending-full.
REQ-026 Out_Byte SHALL be 0 whenever Out_Valid is low.

Reset
REQ-027 RST low SHALL immediately force the following: state IDLE, index 0, shift and pending registers 0, pending-full 0, Out_Valid 0, Out_Byte 0, Busy 0, Overrun 0.
REQ-028 Reset asserted mid-transfer SHALL abandon the in-flight result; no partial bytes are emitted after reset release.
REQ-029 After RST deasserts, the first Result_Valid SHALL be honoured from the first active clock edge.

Structure
REQ-030 The default RESULT_WIDTH SHALL derive from OPERAND_WIDTH (2*OPERAND_WIDTH) in the shared macros header; the state encodings SHALL also be defined there.
REQ-031 The block SHALL be a single module with no sub-modules; the pending register is inline.
REQ-032 All state SHALL be in one clock domain, with no combinational path from Result_Valid to Out_Valid.

Verification
REQ-033 Result=16'hA55A pulse with Out_Ready held 1 -> Out_Byte 8'h5A then 8'hA5 on consecutive cycles starting 1 cycle after the pulse; Busy low after the second transfer.
REQ-034 Result=16'h1234 pulse with Out_Ready low for 5 cycles -> Out_Byte holds 8'h34 with Out_Valid high throughout; 8'h12 follows the first accepted cycle.
REQ-035 Pulses 16'h0001, 16'h0002, 16'h0003 on back-to-back cycles with Out_Ready low -> 16'h0003 dropped, Overrun=1; releasing Out_Ready gives the byte stream 01,00,02,00.
REQ-036 A new pulse on the cycle the last byte of 16'hBEEF transfers -> the next word's byte 0 appears on the following cycle; Overrun stays 0.
REQ-037 RST pulsed low while byte 0 of 16'hCAFE is stalled -> all outputs 0 immediately; no 8'hCA is emitted after release.
REQ-038 Ovr_Clr asserted on the same cycle as an overrun drop -> Overrun remains 1; Ovr_Clr alone on the next cycle -> Overrun 0.
